// File: rtl/store_buffer_pkg.sv
// Shared constants and entry layout for the store buffer.
// Other files import this package.
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_ADDR_W        = 30;
    localparam int SB_WEB_W         = 4;
    localparam int SB_DATA_W        = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_WEB_W-1:0]  web;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO of pending stores that shares memory port B with loads.
// Loads take the port unless they hit a pending store or the FIFO is full; otherwise the head drains.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_web,
    input  logic [31:0] st_dib,
    output logic        st_ready,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_di
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    sb_entry_t        entry_q [DEPTH];

    logic [DEPTH-1:0] match;
    logic             hazard;
    logic             full;
    logic             enq;
    logic             ld_issue;
    logic             drain;
    sb_entry_t        head_ent;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // An entry is live when its distance from head is below the occupancy count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PTR_W-1:0] offset;
        assign offset   = PTR_W'(i) - head_q;
        assign match[i] = ({1'b0, offset} < count_q) && (entry_q[i].addr == ld_addr[31:2]);
    end

    assign hazard   = ld_req && (|match);
    assign full     = (count_q == FULL_CNT);
    assign st_ready = !full;
    assign enq      = st_valid && st_ready && (|st_web);
    assign ld_issue = ld_req && !hazard && !full;
    assign drain    = !ld_issue && (count_q != '0);
    assign ld_stall = ld_req && !ld_issue;
    assign head_ent = entry_q[head_q];

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 4'b0000;
        mem_addr = 32'h0;
        mem_di   = 32'h0;
        if (ld_issue) begin
            mem_en   = 1'b1;
            mem_addr = {ld_addr[31:2], 2'b00};
        end else if (drain) begin
            mem_en   = 1'b1;
            mem_we   = head_ent.web;
            mem_addr = {head_ent.addr, 2'b00};
            mem_di   = head_ent.data;
        end
    end

    always_comb begin
        head_d  = drain ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        case ({enq, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is only meaningful while counted as live, so it carries no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_q[tail_q] <= '{addr: st_addr[31:2], web: st_web, data: st_dib};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized phase
// checked every cycle against a queue-based model of pending stores.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_web;
    logic [31:0] st_dib;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_di;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    // Pending stores in enqueue order: {word addr[29:0], web[3:0], data[31:0]}.
    logic [65:0] exp_q[$];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_web   (st_web),
        .st_dib   (st_dib),
        .st_ready (st_ready),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_stall (ld_stall),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_di   (mem_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from the negedge, check outputs against the model, then advance the model.
    task automatic step(input logic sv, input logic [31:0] sa, input logic [3:0] sw,
                        input logic [31:0] sd, input logic lr, input logic [31:0] la,
                        input string tag);
        logic        full;
        logic        haz;
        logic        ld_go;
        logic        dr;
        logic [65:0] head;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_di;
        st_valid = sv;
        st_addr  = sa;
        st_web   = sw;
        st_dib   = sd;
        ld_req   = lr;
        ld_addr  = la;
        #1;
        full = (exp_q.size() >= DEPTH);
        haz  = 1'b0;
        foreach (exp_q[k]) if (lr && exp_q[k][65:36] == la[31:2]) haz = 1'b1;
        ld_go = lr && !haz && !full;
        dr    = !ld_go && (exp_q.size() != 0);
        head  = (exp_q.size() != 0) ? exp_q[0] : 66'h0;
        e_en = 1'b0; e_we = 4'h0; e_addr = 32'h0; e_di = 32'h0;
        if (ld_go) begin
            e_en = 1'b1; e_addr = {la[31:2], 2'b00};
        end else if (dr) begin
            e_en = 1'b1; e_we = head[35:32]; e_addr = {head[65:36], 2'b00}; e_di = head[31:0];
        end
        chk({tag, ".st_ready"}, 32'(st_ready), 32'(!full));
        chk({tag, ".ld_stall"}, 32'(ld_stall), 32'(lr && !ld_go));
        chk({tag, ".mem_en"},   32'(mem_en),   32'(e_en));
        chk({tag, ".mem_we"},   32'(mem_we),   32'(e_we));
        chk({tag, ".mem_addr"}, mem_addr,      e_addr);
        chk({tag, ".mem_di"},   mem_di,        e_di);
        @(posedge clk);
        if (dr) void'(exp_q.pop_front());
        if (sv && !full && sw != 4'h0) exp_q.push_back({sa[31:2], sw, sd});
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, tag);
    endtask

    initial begin
        rst = 1'b1;
        st_valid = 1'b0; st_addr = 32'h0; st_web = 4'h0; st_dib = 32'h0;
        ld_req = 1'b0; ld_addr = 32'h0;
        @(negedge clk);
        chk("reset.st_ready", 32'(st_ready), 32'd1);
        chk("reset.mem_en",   32'(mem_en),   32'd0);
        chk("reset.mem_we",   32'(mem_we),   32'd0);
        chk("reset.ld_stall", 32'(ld_stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single store drains on the following cycle.
        step(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, "sw_enq");
        idle("sw_drain");
        idle("sw_empty");

        // Zero byte-enables are discarded.
        step(1'b1, 32'h140, 4'h0, 32'h12345678, 1'b0, 32'h0, "web0_enq");
        idle("web0_after");

        // Loads win while not full; at full the head drains and st_ready drops for one cycle.
        step(1'b1, 32'h10, 4'hF, 32'hA0, 1'b1, 32'h200, "fill0");
        step(1'b1, 32'h14, 4'h3, 32'hA1, 1'b1, 32'h200, "fill1");
        step(1'b1, 32'h18, 4'hC, 32'hA2, 1'b1, 32'h200, "fill2");
        step(1'b1, 32'h1C, 4'h1, 32'hA3, 1'b1, 32'h200, "fill3");
        step(1'b1, 32'h20, 4'hF, 32'hA4, 1'b1, 32'h200, "full");
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h200, "after_full");
        repeat (4) idle("fill_drain");

        // Load hits a pending byte store: stall until it drains.
        step(1'b1, 32'h103, 4'h8, 32'h55000000, 1'b0, 32'h0, "haz_enq");
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, "haz_stall");
        step(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, "haz_issue");

        // Six stores across pointer wrap with interleaved drains.
        step(1'b1, 32'h300, 4'hF, 32'h1, 1'b1, 32'h800, "wrap_a");
        step(1'b1, 32'h304, 4'hF, 32'h2, 1'b1, 32'h800, "wrap_b");
        step(1'b1, 32'h308, 4'hF, 32'h3, 1'b1, 32'h800, "wrap_c");
        step(1'b1, 32'h30C, 4'hF, 32'h4, 1'b1, 32'h800, "wrap_d");
        idle("wrap_drain_a");
        step(1'b1, 32'h310, 4'hF, 32'h5, 1'b0, 32'h0, "wrap_e");
        step(1'b1, 32'h314, 4'hF, 32'h6, 1'b0, 32'h0, "wrap_f");
        repeat (4) idle("wrap_tail");

        // Randomized traffic over a small address window to provoke hazards.
        for (int n = 0; n < 300; n++) begin
            logic        sv;
            logic [3:0]  sw;
            logic [31:0] sa;
            logic [31:0] la;
            logic        lr;
            sv = 1'($urandom_range(0, 1));
            sw = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            sa = 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            lr = ($urandom_range(0, 2) != 0);
            la = 32'h400 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
            step(sv, sa, sw, 32'($urandom), lr, la, "rand");
        end
        repeat (5) idle("rand_flush");

        // Reset with three pending entries clears everything immediately.
        step(1'b1, 32'h500, 4'hF, 32'hB0, 1'b1, 32'h900, "rst_fill0");
        step(1'b1, 32'h504, 4'hF, 32'hB1, 1'b1, 32'h900, "rst_fill1");
        step(1'b1, 32'h508, 4'hF, 32'hB2, 1'b1, 32'h900, "rst_fill2");
        st_valid = 1'b0; ld_req = 1'b0; st_web = 4'h0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async.mem_en",   32'(mem_en),   32'd0);
        chk("rst_async.mem_we",   32'(mem_we),   32'd0);
        chk("rst_async.st_ready", 32'(st_ready), 32'd1);
        chk("rst_async.ld_stall", 32'(ld_stall), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) idle("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued store entries (power of two, >=2).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port st_valid, input, 1, store request from the load/store unit this cycle.
REQ-005 SHALL have port st_addr, input, 32, store byte address; only bits [31:2] are stored.
REQ-006 SHALL have port st_web, input, 4, per-byte write enables, already lane-aligned.
REQ-007 SHALL have port st_dib, input, 32, write data, already lane-aligned.
REQ-008 SHALL have port st_ready, output, 1, buffer can accept a store this cycle.
REQ-009 SHALL have port ld_req, input, 1, load request this cycle.
REQ-010 SHALL have port ld_addr, input, 32, load byte address.
REQ-011 SHALL have port ld_stall, output, 1, load not issued this cycle; requester holds ld_req/ld_addr.
REQ-012 SHALL have port mem_en, output, 1, memory port B enable.
REQ-013 SHALL have port mem_we, output, 4, memory port B byte write enables.
REQ-014 SHALL have port mem_addr, output, 32, memory port B byte address, word-aligned ([1:0]=0).
REQ-015 SHALL have port mem_di, output, 32, memory port B write data.

Function
REQ-016 SHALL hold a circular FIFO of DEPTH entries {word address [29:0], web [3:0], data [31:0]} with head pointer, tail pointer and occupancy count (width log2(DEPTH)+1).
REQ-017 SHALL assert st_ready combinationally iff count < DEPTH; no same-cycle pass-through when full.
REQ-018 SHALL enqueue at tail on a rising edge where st_valid && st_ready && st_web != 0; st_valid with st_web == 0 is discarded.
REQ-019 SHALL compute load hazard = ld_req && any valid entry's word address == ld_addr[31:2]; the incoming st_* store is excluded from the compare.
REQ-020 SHALL issue a load (mem_en=1, mem_we=0, mem_addr={ld_addr[31:2],2'b00}, mem_di=0, ld_stall=0) when ld_req && !hazard && count < DEPTH.
REQ-021 SHALL otherwise drain the head when count != 0: mem_en=1, mem_we=head web, mem_addr={head addr,2'b00}, mem_di=head data; head advances and that entry is retired at the edge.
REQ-022 SHALL assert ld_stall whenever ld_req is high and the load is not issued per REQ-020 (hazard, or buffer full, in which case draining takes priority to prevent starvation).
REQ-023 SHALL drive mem_en=0, mem_we=0, mem_addr=0, mem_di=0 when neither a load nor a drain occurs.
REQ-024 SHALL keep count unchanged on a cycle with both enqueue and drain; increment on enqueue only; decrement on drain only.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH without a bubble.
REQ-026 SHALL retire stores to memory in strict enqueue order.
REQ-027 SHALL make all memory-port and handshake outputs combinational from registered state and current inputs; load data returns from memory one cycle later, outside this block.

Reset
REQ-028 SHALL on rst assertion immediately clear head, tail and count to 0, making st_ready=1, ld_stall=ld_req-dependent (no hazard), mem_en=0, mem_we=0.
REQ-029 SHALL discard all pending entries when reset asserts mid-operation; entry payload registers need no reset.

Structure
REQ-030 SHALL place the entry field widths and the default DEPTH constant in the shared core package.
REQ-031 SHALL be a single module; the address-match comparator array may be a generate loop, no sub-module.

Verification
REQ-032 Enqueue SW addr 0x100, web 1111, data 0xDEADBEEF, no ld_req -> next cycle mem_en=1, mem_we=1111, mem_addr=0x100, mem_di=0xDEADBEEF; count returns to 0.
REQ-033 Hold ld_req continuously at 0x200 (no hazard) while enqueuing 4 stores -> loads issue until count=4, then ld_stall=1 and head drains, st_ready=0 for exactly that full cycle.
REQ-034 Pending SB to 0x103 (web 1000), ld_req at 0x100 -> ld_stall=1 until that entry drains, then load issues with mem_we=0, mem_addr=0x100.
REQ-035 Enqueue 6 stores across pointer wrap with DEPTH=4 and interleaved drains -> memory writes observed in exact enqueue order, no loss or duplication.
REQ-036 st_valid with st_web=0000 -> no enqueue, count unchanged, no memory write.
REQ-037 Assert rst with 3 pending entries -> count=0 and mem_en=0 immediately (asynchronously); no pending entry is ever written after reset release.
